seq_detect_ctrl: RTL

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_detect_pkg.sv | 14 +
 rtl/seq_match_shift.sv | 65 ++++++
 rtl/seq_detect_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial pattern detector: default sizes and
// the controller state encoding.
package seq_detect_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_match_shift.sv
// History shift register, fill counter and length-masked comparator.
// hit_o is combinational and reflects the history as it will be after this
// edge, so the controller can register the match pulse on the same edge that
// samples the completing bit. MAX_LEN must be at least 2.
module seq_match_shift #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clear_i,
    input  logic               shift_i,
    input  logic               bit_i,
    input  logic               overlap_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    output logic               hit_o
);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] mask;

    // Compare only the low len bits of history against the pattern.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_i));
        end
    end

    assign fill_inc = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

    // Next history/fill and the hit decision on the updated history.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        hit_o  = 1'b0;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_i) begin
            hist_d = {hist_q[MAX_LEN-2:0], bit_i};
            fill_d = fill_inc;
            hit_o  = (fill_inc >= len_i) && (((hist_d ^ pattern_i) & mask) == '0);
            // Non-overlapping mode starts a fresh window after each match.
            if (hit_o && !overlap_i) begin
                fill_d = '0;
            end
        end
    end

    // History and fill registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector controller: configuration shadows, run FSM,
// saturating match counter and registered status outputs.
//
//   state    | meaning
//   ST_IDLE  | not running; config writes and start accepted
//   ST_ARMED | detecting; in_valid bits are shifted and compared
//   ST_DONE  | target match count reached; waits for start/abort
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               busy,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               done,
    output logic               cfg_err
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               match_q, match_d;
    logic               err_q, err_d;
    logic               busy_q, done_q;
    logic               clear, shift, hit, start_ok;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    seq_match_shift #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shift (
        .clk       (clk),
        .rstn      (rstn),
        .clear_i   (clear),
        .shift_i   (shift),
        .bit_i     (in_bit),
        .overlap_i (ovl_q),
        .pattern_i (pat_q),
        .len_i     (len_q),
        .hit_o     (hit)
    );

    // Next-state, config shadow and counter logic.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        match_d  = 1'b0;
        err_d    = 1'b0;
        clear    = 1'b0;
        shift    = 1'b0;
        start_ok = 1'b0;

        // Config written this cycle is what a simultaneous start is judged by.
        if (cfg_we) begin
            if (state_q == ST_ARMED) begin
                err_d = 1'b1;
            end else begin
                pat_d = cfg_pattern;
                len_d = cfg_len;
                ovl_d = cfg_overlap;
                tgt_d = cfg_target;
            end
        end
        start_ok = (len_d != '0) && (len_d <= LEN_W'(MAX_LEN));

        case (state_q)
            ST_ARMED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    shift = in_valid;
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                        if ((tgt_q != '0) && (cnt_inc >= tgt_q)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            default: begin
                if ((state_q == ST_DONE) && abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    if (start_ok) begin
                        state_d = ST_ARMED;
                        clear   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // State, shadow config, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            err_q   <= err_d;
            busy_q  <= (state_d == ST_ARMED);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign busy      = busy_q;
    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign done      = done_q;
    assign cfg_err   = err_q;

endmodule
